// File: rtl/cpu_ex.sv
// cpu_ex: execute stage with single-cycle ALU, EX/MEM pipeline latch and HI/LO registers.
// Define CPU_EX_MULDIV_EN to build the 33-cycle MULT/MULTU/DIV/DIVU unit; otherwise those are NOPs.
`ifndef CPU_EX_DEFINES
`define CPU_EX_DEFINES
`define CON_MSB        7
`define CON_LSB        0
`define CON_ALU_OP     4:0
`define CON_ALU_SRC    5
`define REG_WRITE_EN_F 1'b0
`endif

module cpu_ex (
  input  logic                      clk_i,
  input  logic                      clr_ni,
  input  logic [31:0]               current_pc_i,
  input  logic [31:0]               ins_i,
  input  logic [`CON_MSB:`CON_LSB]  controls_i,
  input  logic [31:0]               reg_read1_data_i,
  input  logic [31:0]               reg_read2_data_i,
  input  logic [31:0]               imm_ext_i,
  input  logic                      reg_write_en_i,
  input  logic [4:0]                reg_write_num_i,
  input  logic                      flush_i,
  output logic [31:0]               current_pc_ex_o,
  output logic [31:0]               ins_ex_o,
  output logic [`CON_MSB:`CON_LSB]  controls_ex_o,
  output logic [31:0]               reg_read2_data_ex_o,
  output logic [31:0]               alu_result_o,
  output logic                      reg_write_en_ex_o,
  output logic [4:0]                reg_write_num_ex_o,
  output logic                      stall_ex_o,
  output logic [31:0]               hi_o,
  output logic [31:0]               lo_o
);

  localparam logic [4:0] OpAdd  = 5'd0,  OpAddu = 5'd1,  OpSub  = 5'd2,  OpSubu = 5'd3;
  localparam logic [4:0] OpAnd  = 5'd4,  OpOr   = 5'd5,  OpXor  = 5'd6,  OpNor  = 5'd7;
  localparam logic [4:0] OpSlt  = 5'd8,  OpSltu = 5'd9,  OpSll  = 5'd10, OpSrl  = 5'd11;
  localparam logic [4:0] OpSra  = 5'd12, OpLui  = 5'd13, OpMfhi = 5'd14, OpMflo = 5'd15;
  localparam logic [4:0] OpMthi = 5'd16, OpMtlo = 5'd17, OpMult = 5'd18, OpMultu = 5'd19;
  localparam logic [4:0] OpDiv  = 5'd20, OpDivu = 5'd21, OpSllv = 5'd22, OpSrlv = 5'd23;
  localparam logic [4:0] OpSrav = 5'd24;

  logic [4:0]  alu_op;
  logic [31:0] op_a, op_b, alu_res;
  logic [4:0]  shamt, vshamt;
  logic        is_muldiv, no_gpr_write;

  assign alu_op       = controls_i[`CON_ALU_OP];
  assign op_a         = reg_read1_data_i;
  assign op_b         = controls_i[`CON_ALU_SRC] ? imm_ext_i : reg_read2_data_i;
  assign shamt        = ins_i[10:6];
  assign vshamt       = op_b[4:0];
  assign is_muldiv    = (alu_op == OpMult) || (alu_op == OpMultu) ||
                        (alu_op == OpDiv)  || (alu_op == OpDivu);
  assign no_gpr_write = is_muldiv || (alu_op == OpMthi) || (alu_op == OpMtlo);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      OpAdd, OpAddu: alu_res = op_a + op_b;
      OpSub, OpSubu: alu_res = op_a - op_b;
      OpAnd:         alu_res = op_a & op_b;
      OpOr:          alu_res = op_a | op_b;
      OpXor:         alu_res = op_a ^ op_b;
      OpNor:         alu_res = ~(op_a | op_b);
      OpSlt:         alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OpSltu:        alu_res = {31'd0, op_a < op_b};
      OpSll:         alu_res = op_b << shamt;
      OpSrl:         alu_res = op_b >> shamt;
      OpSra:         alu_res = $signed(op_b) >>> shamt;
      OpSllv:        alu_res = op_a << vshamt;
      OpSrlv:        alu_res = op_a >> vshamt;
      OpSrav:        alu_res = $signed(op_a) >>> vshamt;
      OpLui:         alu_res = {op_b[15:0], 16'd0};
      OpMfhi:        alu_res = hi_o;
      OpMflo:        alu_res = lo_o;
      default:       alu_res = '0;
    endcase
  end

`ifdef CPU_EX_MULDIV_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} md_state_e;

  md_state_e   state_q;
  logic [4:0]  cnt_q;
  logic [63:0] p_q;  // mul: {accumulator, multiplier}; div: {remainder, dividend -> quotient}
  logic [31:0] dvs_q;
  logic        is_div_q, neg_q, rneg_q, dz_q;
  logic [31:0] hi_q, lo_q;

  logic        md_signed;
  logic [31:0] mag_a, mag_b, div_sub, quo, rem;
  logic [32:0] mul_sum, div_shift;
  logic        div_ge;
  logic [63:0] mul_step, div_step, prod;

  always_comb begin
    md_signed = (alu_op == OpMult) || (alu_op == OpDiv);
    mag_a     = (md_signed && op_a[31]) ? -op_a : op_a;
    mag_b     = (md_signed && op_b[31]) ? -op_b : op_b;
    mul_sum   = {1'b0, p_q[63:32]} + {1'b0, (p_q[0] ? dvs_q : 32'd0)};
    mul_step  = {mul_sum, p_q[31:1]};
    div_shift = {p_q[63:32], p_q[31]};
    div_ge    = div_shift >= {1'b0, dvs_q};
    div_sub   = div_shift[31:0] - dvs_q;
    div_step  = div_ge ? {div_sub, p_q[30:0], 1'b1} : {div_shift[31:0], p_q[30:0], 1'b0};
    prod      = neg_q ? -p_q : p_q;
    // A zero divisor leaves the quotient all ones and the dividend as remainder.
    quo       = dz_q ? 32'hFFFF_FFFF : (neg_q ? -p_q[31:0] : p_q[31:0]);
    rem       = rneg_q ? -p_q[63:32] : p_q[63:32];
  end

  assign stall_ex_o = !flush_i && (((state_q == StIdle) && is_muldiv) || (state_q == StBusy));
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      p_q      <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (flush_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_muldiv) begin
            is_div_q <= (alu_op == OpDiv) || (alu_op == OpDivu);
            neg_q    <= md_signed && (op_a[31] ^ op_b[31]);
            rneg_q   <= md_signed && op_a[31];
            dz_q     <= (op_b == 32'd0);
            p_q      <= {32'd0, ((alu_op == OpDiv) || (alu_op == OpDivu)) ? mag_a : mag_b};
            dvs_q    <= ((alu_op == OpDiv) || (alu_op == OpDivu)) ? mag_b : mag_a;
            cnt_q    <= '0;
            state_q  <= StBusy;
          end else if (alu_op == OpMthi) begin
            hi_q <= op_a;
          end else if (alu_op == OpMtlo) begin
            lo_q <= op_a;
          end
        end
        StBusy: begin
          p_q   <= is_div_q ? div_step : mul_step;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= StDone;
        end
        StDone: begin
          hi_q    <= is_div_q ? rem : prod[63:32];
          lo_q    <= is_div_q ? quo : prod[31:0];
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  assign stall_ex_o = 1'b0;
  assign hi_o       = '0;
  assign lo_o       = '0;
`endif

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni || flush_i || stall_ex_o) begin
      current_pc_ex_o     <= '0;
      ins_ex_o            <= '0;
      controls_ex_o       <= '0;
      reg_read2_data_ex_o <= '0;
      alu_result_o        <= '0;
      reg_write_en_ex_o   <= `REG_WRITE_EN_F;
      reg_write_num_ex_o  <= '0;
    end else begin
      current_pc_ex_o     <= current_pc_i;
      ins_ex_o            <= ins_i;
      controls_ex_o       <= controls_i;
      reg_read2_data_ex_o <= reg_read2_data_i;
      alu_result_o        <= alu_res;
      reg_write_en_ex_o   <= no_gpr_write ? `REG_WRITE_EN_F : reg_write_en_i;
      reg_write_num_ex_o  <= reg_write_num_i;
    end
  end

endmodule

// File: doc/cpu_ex.md
CPU_EX -- requirements
Module: cpu_ex

Interface
REQ-001 clk  input  1  global clock; all state updates on posedge.
REQ-002 clr  input  1  global reset; asynchronous, active-low.
REQ-003 current_pc  input  32  PC of the instruction in EX, from ID.
REQ-004 ins  input  32  instruction word in EX, from ID.
REQ-005 controls  input  [`CON_MSB:`CON_LSB]  decoded control bundle; ALU op in field `CON_ALU_OP.
REQ-006 reg_read1_data / reg_read2_data  input  32 each  forwarded register operands A and B.
REQ-007 imm_ext  input  32  sign- or zero-extended immediate; selected as B when controls[`CON_ALU_SRC] is set.
REQ-008 reg_write_en / reg_write_num  input  1 / 5  writeback intent from ID.
REQ-009 flush  input  1  synchronous kill of the EX instruction.
REQ-010 current_pc_ex, ins_ex, controls_ex, reg_read2_data_ex, alu_result, reg_write_en_ex, reg_write_num_ex  output reg  widths as inputs  EX/MEM latch feeding the memory stage.
REQ-011 stall_ex  output  1  combinational; when high, IF/ID hold their contents.
REQ-012 hi / lo  output  32 each  architectural HI/LO registers.

Function
REQ-013 ALU ops ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/LUI are single-cycle: result is latched into alu_result on the next posedge. Add and subtract wrap mod 2^32 with no overflow trap. Shift amount is ins[10:6], or B[4:0] for variable shifts.
REQ-014 MFHI/MFLO return hi/lo as alu_result. MTHI/MTLO write A into hi/lo at the posedge that latches the instruction.
REQ-015 MULT/MULTU/DIV/DIVU are handled by a multiply/divide FSM with states IDLE, BUSY and DONE, plus a 5-bit iteration counter.
REQ-016 IDLE with a mul/div op present: stall_ex=1; operands are captured; go to BUSY with cnt=0.
REQ-017 BUSY: stall_ex=1; one radix-2 shift-add or restoring-subtract step per cycle; cnt+1; go to DONE when cnt==31.
REQ-018 DONE: stall_ex=0; the posedge writes hi/lo, latches the instruction into EX/MEM, and returns to IDLE.
REQ-019 Total stall is 33 cycles. The result is visible on hi/lo the cycle after DONE.
REQ-020 MULT/MULTU results: hi = upper 32 bits of the 64-bit product; lo = lower 32 bits. Signed or unsigned per the op.
REQ-021 DIV/DIVU results: lo = quotient, hi = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
REQ-022 Divide by zero: lo = 32'hFFFFFFFF, hi = dividend. Takes the full 33 cycles; no exception.
REQ-023 While stall_ex=1, the EX/MEM latch loads a bubble: reg_write_en_ex=`REG_WRITE_EN_F, controls_ex=0, ins_ex=0. All other latch fields are 0.
REQ-024 flush=1 overrides everything: EX/MEM loads a bubble, the FSM returns to IDLE, and hi/lo are unchanged, including mid-BUSY. stall_ex drops in the same cycle.
REQ-025 MTHI/MTLO or MFHI/MFLO never reach EX while the FSM is busy, because stall_ex holds them upstream. No HI/LO hazard logic is required.

Reset
REQ-026 clr low asynchronously forces: FSM=IDLE, cnt=0, hi=lo=0, all EX/MEM latch outputs 0, reg_write_en_ex=`REG_WRITE_EN_F.
REQ-027 Reset asserted mid-BUSY discards the operation. After release, stall_ex is 0 until a new mul/div op arrives.

Configuration
REQ-028 Macro CPU_EX_MULDIV_EN: when defined, REQ-015..REQ-022 and REQ-025 apply.
REQ-029 When CPU_EX_MULDIV_EN is undefined: MULT/MULTU/DIV/DIVU pass as NOPs with no register write; MFHI/MFLO return 0; MTHI/MTLO are ignored; stall_ex and hi/lo are tied to 0; no FSM is synthesized.

Verification
REQ-030 ADDU with A=32'hFFFFFFFF, B=1 -> alu_result=0 one cycle later; reg_write_num_ex and reg_write_en_ex match the inputs.
REQ-031 MULT with A=-3, B=7 -> stall_ex high for exactly 33 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFEB; 33 bubbles appear on EX/MEM.
REQ-032 DIV with A=-7, B=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. DIVU with A=5, B=0 -> lo=32'hFFFFFFFF, hi=5.
REQ-033 MULTU with A=B=32'hFFFFFFFF, flush asserted at BUSY cnt=10 -> stall_ex drops that cycle, hi/lo keep their prior values, and the FSM is in IDLE.
REQ-034 clr pulsed low mid-DIV, asynchronous to clk -> all outputs 0 immediately; the next ADDU completes normally in one cycle.
REQ-035 MULT then MFLO back-to-back -> MFLO is held by stall_ex and returns the new lo on alu_result.
